// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one asynchronous SRAM between the instruction-fetch port (IF,
//   read-only) and the data port (MEM, read/write). MEM has fixed priority.
//   Each access runs as a registered FSM transaction with programmable wait
//   states. The pipeline sees stall requests until its own access completes.
//
// Parameters
//   WAIT_RD  extra wait cycles on a read (0..7)
//   WAIT_WR  extra wait cycles on the write strobe (0..7)
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   if_req/if_addr            IF fetch request (held until if_ready)
//   if_rdata/if_ready         IF read data and one-cycle completion pulse
//   mem_req/we/sel/addr/wdata MEM request (held until mem_ready)
//   mem_rdata/mem_ready       MEM read data and one-cycle completion pulse
//   flush                     pipeline flush; aborts only an IF read
//   stallreq_from_if/mem      req & ~ready, per port
//   sram_*                    SRAM pad interface, strobes active-low
module sram_arbiter #(
  parameter int unsigned WAIT_RD = 1,
  parameter int unsigned WAIT_WR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        flush,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe,
  input  logic [31:0] sram_data_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Access latched at grant time; pins are driven only from this register,
  // never straight from the request inputs.
  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  localparam logic [2:0] RD_LAST = 3'(WAIT_RD);
  localparam logic [2:0] WR_LAST = 3'(WAIT_WR);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  // WR needs WAIT_WR+2 cycles, one more than a 3-bit count covers at
  // WAIT_WR=7; the data-hold cycle is tracked by this flag instead.
  logic       wr_hold, wr_hold_nx;
  logic       grant, grant_nx;     // 0 = IF, 1 = MEM
  logic       latch_mem, latch_if, capture;
  req_t       req_q;

  // Only addr[21:2] reaches the SRAM.
  logic unused;
  assign unused = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_hold <= 1'b0;
      grant   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wr_hold <= wr_hold_nx;
      grant   <= grant_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wr_hold_nx   = wr_hold;
    grant_nx     = grant;
    latch_mem    = 1'b0;
    latch_if     = 1'b0;
    capture      = 1'b0;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_be_n    = 4'hF;
    sram_data_oe = 1'b0;
    if_ready     = 1'b0;
    mem_ready    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx     = '0;
        wr_hold_nx = 1'b0;
        if (flush) begin
          state_nx = IDLE;
        end else if (mem_req) begin
          grant_nx  = 1'b1;
          latch_mem = 1'b1;
          state_nx  = mem_we ? WR : RD;
        end else if (if_req) begin
          grant_nx = 1'b0;
          latch_if = 1'b1;
          state_nx = RD;
        end
      end
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'h0;
        // A flushed fetch is dropped even on its final cycle.
        if (flush && !grant) begin
          state_nx = IDLE;
        end else if (cnt == RD_LAST) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      WR: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
        sram_be_n    = ~req_q.sel;
        if (!wr_hold) begin
          sram_we_n = 1'b0;
          if (cnt == WR_LAST) wr_hold_nx = 1'b1;
          else                cnt_nx     = cnt + 3'd1;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if_ready  = ~grant;
        mem_ready = grant;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q     <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if (latch_mem)     req_q      <= '{addr: mem_addr[21:2], sel: mem_sel, wdata: mem_wdata};
      else if (latch_if) req_q.addr <= if_addr[21:2];
      if (capture) begin
        if (grant) mem_rdata <= sram_data_i;
        else       if_rdata  <= sram_data_i;
      end
    end
  end

  assign sram_addr         = req_q.addr;
  assign sram_data_o       = req_q.wdata;
  assign stallreq_from_if  = if_req  & ~if_ready;
  assign stallreq_from_mem = mem_req & ~mem_ready;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Arbitrates a single off-chip asynchronous SRAM between the instruction-fetch port (IF, read-only) and the data port (MEM, read/write), and sequences each access with programmable wait states. It sits between the IF/MEM stages and the SRAM pins. It raises stall requests into the pipeline controller until the granted access completes. Each access is a registered FSM transaction; MEM has fixed priority over IF.

## Interface
- WAIT_RD, 1: extra wait cycles added to a read access (0..7)
- WAIT_WR, 1: extra wait cycles added to the write strobe (0..7)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- if_req  in  1  IF read request, held until if_ready
- if_addr  in  32  IF byte address (word-aligned)
- if_rdata  out  32  IF read data, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM request, held until mem_ready
- mem_we  in  1  1=write, 0=read
- mem_sel  in  4  byte lane select for writes
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  write data
- mem_rdata  out  32  MEM read data, valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse for MEM
- flush  in  1  pipeline flush from controller
- stallreq_from_if  out  1  = if_req & ~if_ready (combinational)
- stallreq_from_mem  out  1  = mem_req & ~mem_ready (combinational)
- sram_addr  out  20  word address = granted addr[21:2]
- sram_data_o  out  32  write data to pad
- sram_data_oe  out  1  pad output enable
- sram_data_i  in  32  read data from pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
- sram_be_n  out  4  active-low byte enables

## Operation
- States: IDLE, RD, WR, DONE. A 3-bit wait counter and a 1-bit grant register (0=IF, 1=MEM) are kept.
- IDLE arbitration, evaluated each cycle in this order:
  - flush=1: no grant.
  - mem_req=1: grant MEM. Latch addr, sel and wdata. Go to WR if mem_we=1, else RD.
  - if_req=1: grant IF and go to RD.
  - Otherwise stay in IDLE.
- RD:
  - Lasts WAIT_RD+1 cycles.
  - ce_n=0, oe_n=0, be_n=4'b0000, data_oe=0.
  - On the last RD cycle, sram_data_i is registered into the granted port's rdata. Then go to DONE.
- WR:
  - Lasts WAIT_WR+2 cycles. ce_n=0, oe_n=1, data_oe=1, be_n=~sel.
  - we_n=0 for the first WAIT_WR+1 cycles and 1 in the final cycle (data hold). Then go to DONE.
- DONE:
  - Lasts 1 cycle. The granted port's ready=1; all strobes are inactive and data_oe=0. Go to IDLE.
  - A request still asserted during DONE is not re-granted. The requester's pipeline advances on this edge.
- flush during RD with grant=IF: abort the read. Go to IDLE next cycle with strobes released; if_ready is never asserted for the aborted fetch.
- flush during a MEM read or any write: no effect. A write is never aborted.
- The ungranted port sees ready=0 and its stall request remains high.
- if_rdata and mem_rdata hold their last captured value outside DONE.

## Timing
- Reset (rst=0 at a clk edge):
  - State goes to IDLE and the counter to 0.
  - ce_n, oe_n and we_n go to 1; be_n goes to 4'b1111.
  - sram_addr, sram_data_o and both rdata outputs go to 0.
  - data_oe and both ready outputs go to 0.
- Reset mid-access drops all strobes on that edge; no completion pulse follows.
- Read latency: request sampled in IDLE at cycle 0. RD occupies cycles 1..WAIT_RD+1, and ready is high in cycle WAIT_RD+2.
- Write latency: ready is high in cycle WAIT_WR+3.
- Back-to-back: after DONE, the next grant is taken in the following IDLE cycle, so there is one idle bus cycle between accesses.
- Simultaneous mem_req and if_req in IDLE: MEM wins. IF starts in the IDLE cycle after MEM's DONE.
- stall outputs are combinational from the inputs and registered ready; no other combinational paths from inputs to SRAM pins.

## Test plan
- IF read with WAIT_RD=1: SRAM model returns 0x3C000001 at word 0x40, if_addr=0x100. Expect:
  - if_ready pulses in cycle 3 with if_rdata=0x3C000001.
  - stallreq_from_if is high in cycles 0..2.
- MEM byte write with WAIT_WR=1: mem_addr=0x204, mem_sel=4'b0010, wdata=0xAABBCCDD. Expect:
  - sram_addr=0x81 and be_n=4'b1101.
  - we_n low for exactly 2 cycles, with data_oe high across all 3 WR cycles.
  - mem_ready in cycle 4; only byte 1 (0xCC) changes in the model.
- Contention: if_req and mem_req (read) rise together. Expect MEM to complete first, then IF to be granted after one IDLE cycle, with no overlapping strobes.
- Flush during IF RD (WAIT_RD=3, flush in second RD cycle). Expect:
  - State IDLE next cycle, oe_n=1, and no if_ready pulse.
  - A following mem_req is granted immediately.
- Flush during a MEM write. Expect the write to complete normally: full we_n pulse and mem_ready asserted.
- rst=0 asserted in the middle of a WR. Expect:
  - All strobes high and data_oe=0 on that edge.
  - No ready pulses.
  - After release, a fresh IF read completes with correct latency.
